// File: rtl/trig_readout_sched.sv
// rtl/trig_readout_sched.sv - trigger queue and per-beat URAM readout scheduler
module trig_readout_sched #(
    parameter int ADDRLEN     = 15,
    parameter int DEPTH       = 16,
    parameter int NCHAN       = 8,
    parameter int EVNUMLEN    = 16,
    parameter int READOUT_LEN = 1024
) (
    input  logic                     memclk_i,
    input  logic                     memclk_rst_i,
    input  logic                     run_stop_i,
    input  logic [ADDRLEN-1:0]       trig_time_i,
    input  logic                     trig_valid_i,
    output logic                     trig_ready_o,
    input  logic [ADDRLEN-1:0]       lookback_i,
    input  logic [NCHAN-1:0]         chan_mask_i,
    output logic [ADDRLEN-1:0]       rd_addr_o,
    output logic [NCHAN-1:0]         rd_chan_en_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic                     rd_last_o,
    output logic                     begin_o,
    output logic [EVNUMLEN-1:0]      event_no_o,
    output logic [ADDRLEN-1:0]       trig_time_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [15:0]              drop_count_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0]    FULL_CNT  = CNTW'(DEPTH);
    localparam logic [ADDRLEN-1:0] LAST_BEAT = ADDRLEN'(READOUT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Queue storage, one array per field
    logic [ADDRLEN-1:0]  r_q_start [DEPTH];
    logic [ADDRLEN-1:0]  r_q_time  [DEPTH];
    logic [NCHAN-1:0]    r_q_mask  [DEPTH];
    logic [EVNUMLEN-1:0] r_q_evno  [DEPTH];

    logic [PTRW-1:0]     r_wr_ptr;
    logic [PTRW-1:0]     r_rd_ptr;
    logic [CNTW-1:0]     r_count;
    logic [EVNUMLEN-1:0] r_ev_cnt;
    logic [15:0]         r_drop_cnt;
    logic                r_trig_ready;

    logic [ADDRLEN-1:0]  r_rd_addr;
    logic [NCHAN-1:0]    r_rd_chan;
    logic [EVNUMLEN-1:0] r_event_no;
    logic [ADDRLEN-1:0]  r_trig_time;
    logic [ADDRLEN-1:0]  r_beat;
    logic                r_first;
    logic                r_begin;

    logic                w_push;
    logic                w_drop;
    logic                w_pop;
    logic                w_xfer;
    logic                w_last_xfer;
    logic                w_has_work;
    logic [CNTW-1:0]     w_count_next;

    // Queue control: fullness is judged on the start-of-cycle count, so a same-cycle pop never frees room
    always_comb begin
        w_push       = trig_valid_i & ~run_stop_i & (r_count != FULL_CNT);
        w_drop       = trig_valid_i & ~run_stop_i & (r_count == FULL_CNT);
        w_pop        = (r_state == S_LOAD) & ~run_stop_i;
        w_xfer       = (r_state == S_STREAM) & rd_ready_i & ~run_stop_i;
        w_last_xfer  = w_xfer & (r_beat == LAST_BEAT);
        w_has_work   = (r_count != '0) | w_push;
        w_count_next = r_count + CNTW'(w_push) - CNTW'(w_pop);
    end

    // Queue payload write; the start address is the lookback-adjusted trigger time, wrapping naturally
    always_ff @(posedge memclk_i) begin
        if (w_push) begin
            r_q_start[r_wr_ptr] <= trig_time_i - lookback_i;
            r_q_time[r_wr_ptr]  <= trig_time_i;
            r_q_mask[r_wr_ptr]  <= chan_mask_i;
            r_q_evno[r_wr_ptr]  <= r_ev_cnt;
        end
    end

    // Pointers, occupancy, event numbering and drop accounting; a stop pulse flushes all of it
    always_ff @(posedge memclk_i or posedge memclk_rst_i) begin
        if (memclk_rst_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ev_cnt     <= '0;
            r_drop_cnt   <= '0;
            r_trig_ready <= 1'b0;
        end else if (run_stop_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ev_cnt     <= '0;
            r_drop_cnt   <= '0;
            r_trig_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTRW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTRW'(1);
            end
            if (trig_valid_i) begin
                r_ev_cnt <= r_ev_cnt + EVNUMLEN'(1);
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            r_count      <= w_count_next;
            r_trig_ready <= (w_count_next != FULL_CNT);
        end
    end

    // FSM state register
    always_ff @(posedge memclk_i or posedge memclk_rst_i) begin
        if (memclk_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; an incoming push counts as work so a lone trigger is loaded the very next cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_has_work) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_next = S_STREAM;
            end
            S_STREAM: begin
                if (w_last_xfer) begin
                    w_state_next = w_has_work ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (run_stop_i) begin
            w_state_next = S_IDLE;
        end
    end

    // Readout registers: loaded from the queue head in LOAD, address and beat advance only on a transfer
    always_ff @(posedge memclk_i or posedge memclk_rst_i) begin
        if (memclk_rst_i) begin
            r_rd_addr   <= '0;
            r_rd_chan   <= '0;
            r_event_no  <= '0;
            r_trig_time <= '0;
            r_beat      <= '0;
            r_first     <= 1'b0;
            r_begin     <= 1'b0;
        end else begin
            r_begin <= w_xfer & r_first;
            if (w_pop) begin
                r_rd_addr   <= r_q_start[r_rd_ptr];
                r_rd_chan   <= r_q_mask[r_rd_ptr];
                r_event_no  <= r_q_evno[r_rd_ptr];
                r_trig_time <= r_q_time[r_rd_ptr];
                r_beat      <= '0;
                r_first     <= 1'b1;
            end else if (w_xfer) begin
                r_rd_addr <= r_rd_addr + ADDRLEN'(1);
                r_beat    <= r_beat + ADDRLEN'(1);
                r_first   <= 1'b0;
            end
            if (run_stop_i) begin
                r_first <= 1'b0;
            end
        end
    end

    // Output mapping; stream qualifiers derive from the state register so reset clears them at once
    always_comb begin
        rd_valid_o   = (r_state == S_STREAM);
        rd_last_o    = (r_state == S_STREAM) & (r_beat == LAST_BEAT);
        busy_o       = (r_state != S_IDLE) | (r_count != '0);
        rd_addr_o    = r_rd_addr;
        rd_chan_en_o = r_rd_chan;
        event_no_o   = r_event_no;
        trig_time_o  = r_trig_time;
        begin_o      = r_begin;
        occupancy_o  = r_count;
        drop_count_o = r_drop_cnt;
        trig_ready_o = r_trig_ready;
    end

endmodule
